// File: rtl/des_pkg.sv
// Shared definitions for the DES round controller: FSM states, default
// round count and the per-round key rotation table.
package des_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IP    = 3'd1,
    ST_ROUND = 3'd2,
    ST_FP    = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int ROUNDS_DEFAULT = 16;

  // Encryption rotate amounts, 2 bits per round, round 0 in the LSBs.
  // Rounds 0,1,8,15 rotate by one, all others by two.
  localparam logic [31:0] SHIFT_TABLE = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

endpackage

// File: rtl/des_shift_sched.sv
// Key schedule lookup: maps the current round and cipher direction to the
// rotate amount and rotate direction of the C/D key halves.
module des_shift_sched
  import des_pkg::*;
(
  input  logic [3:0] i_round_idx,
  input  logic       i_mode,
  output logic [1:0] o_key_shift,
  output logic       o_key_dir
);

  logic [1:0] w_enc_shift;

  assign w_enc_shift = SHIFT_TABLE[{i_round_idx, 1'b0} +: 2];

  // Decryption runs the schedule backwards starting from the PC-1 key, so the
  // first round needs no rotation; later rounds reuse the encryption amounts.
  assign o_key_shift = (i_mode && (i_round_idx == 4'd0)) ? 2'd0 : w_enc_shift;
  assign o_key_dir   = i_mode;

endmodule

// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts a block, strobes the initial permutation and
// key load, runs ROUNDS Feistel rounds with the key rotation schedule, strobes
// the final permutation and holds the result valid until it is taken.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_valid_in,
  output logic       start_ready_out,
  input  logic       mode_in,
  output logic       ip_load_out,
  output logic       key_load_out,
  output logic       round_en_out,
  output logic [3:0] round_idx_out,
  output logic [1:0] key_shift_out,
  output logic       key_dir_out,
  output logic       fp_load_out,
  output logic       out_valid_out,
  input  logic       out_ready_in,
  output logic       busy_out
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round_idx;
  logic       r_mode;
  logic       w_accept;
  logic [1:0] w_sched_shift;
  logic       w_sched_dir;

  des_shift_sched u_shift_sched (
    .i_round_idx (r_round_idx),
    .i_mode      (r_mode),
    .o_key_shift (w_sched_shift),
    .o_key_dir   (w_sched_dir)
  );

  assign w_accept      = start_valid_in && (r_state == ST_IDLE);
  assign busy_out      = (r_state != ST_IDLE);
  assign round_idx_out = r_round_idx;

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cipher direction captured at accept; round counter cleared in IP, advanced
  // through ROUND and left at its final value until the next block.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode      <= 1'b0;
      r_round_idx <= 4'd0;
    end else begin
      if (w_accept) begin
        r_mode <= mode_in;
      end
      if (r_state == ST_IP) begin
        r_round_idx <= 4'd0;
      end else if ((r_state == ST_ROUND) && (r_round_idx != LAST_IDX)) begin
        r_round_idx <= r_round_idx + 4'd1;
      end
    end
  end

  // Next-state and Moore outputs; strobes come from distinct states so they
  // can never overlap, and the key schedule is only visible during ROUND.
  always_comb begin
    w_state_nxt     = r_state;
    start_ready_out = 1'b0;
    ip_load_out     = 1'b0;
    key_load_out    = 1'b0;
    round_en_out    = 1'b0;
    fp_load_out     = 1'b0;
    out_valid_out   = 1'b0;
    key_shift_out   = 2'd0;
    key_dir_out     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready_out = 1'b1;
        if (start_valid_in) begin
          w_state_nxt = ST_IP;
        end
      end
      ST_IP: begin
        ip_load_out  = 1'b1;
        key_load_out = 1'b1;
        w_state_nxt  = ST_ROUND;
      end
      ST_ROUND: begin
        round_en_out  = 1'b1;
        key_shift_out = w_sched_shift;
        key_dir_out   = w_sched_dir;
        if (r_round_idx == LAST_IDX) begin
          w_state_nxt = ST_FP;
        end
      end
      ST_FP: begin
        fp_load_out = 1'b1;
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid_out = 1'b1;
        if (out_ready_in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
